// File: rtl/wallclock_hms.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of the 1 s divider level,
// with a RUN/SET_HH/SET_MM/SET_SS edit FSM driven by push-button strobes.
module wallclock_hms #(
  parameter int          HOURS  = 24,
  parameter logic [7:0]  RST_HH = 8'h00,
  parameter logic [7:0]  RST_MM = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1s,
  input  logic       set_mode,
  input  logic       sel,
  input  logic       inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] edit_field,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_t;

  localparam logic [7:0] HH_MAX = (HOURS == 12) ? 8'h11 : 8'h23;

  // sel and inc are single-cycle strobes sampled on every clk edge; there is no
  // back-pressure, each edge on which a strobe is high counts as one event.
  state_t     r_state;
  state_t     w_state_next;
  logic       r_prev;
  logic       r_day;
  logic [7:0] r_hh;
  logic [7:0] r_mm;
  logic [7:0] r_ss;

  logic       w_tick;
  logic       w_ss_wrap;
  logic       w_mm_wrap;
  logic       w_hh_wrap;
  logic [7:0] w_ss_next;
  logic [7:0] w_mm_next;
  logic [7:0] w_hh_next;

  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      else                return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic logic [7:0] hours_inc(input logic [7:0] v);
    if (v == HH_MAX)          return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_tick    = clk_1s & ~r_prev;
  assign w_ss_wrap = (r_ss == 8'h59);
  assign w_mm_wrap = (r_mm == 8'h59);
  assign w_hh_wrap = (r_hh == HH_MAX);
  assign w_ss_next = bcd60_inc(r_ss);
  assign w_mm_next = bcd60_inc(r_mm);
  assign w_hh_next = hours_inc(r_hh);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:    if (set_mode) w_state_next = SET_HH;
      SET_HH: if (!set_mode) w_state_next = RUN; else if (sel) w_state_next = SET_MM;
      SET_MM: if (!set_mode) w_state_next = RUN; else if (sel) w_state_next = SET_SS;
      SET_SS: if (!set_mode) w_state_next = RUN; else if (sel) w_state_next = SET_HH;
      default: w_state_next = RUN;
    endcase
  end

  // Time registers: the decision uses the current state, so a tick on the
  // RUN->SET_HH edge still counts and a tick on the SET->RUN edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hh   <= RST_HH;
      r_mm   <= RST_MM;
      r_ss   <= 8'h00;
      r_day  <= 1'b0;
      r_prev <= 1'b1;
    end else begin
      r_prev <= clk_1s;
      r_day  <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_tick) begin
            r_ss <= w_ss_next;
            if (w_ss_wrap) begin
              r_mm <= w_mm_next;
              if (w_mm_wrap) begin
                r_hh  <= w_hh_next;
                r_day <= w_hh_wrap;
              end
            end
          end
        end
        SET_HH: if (inc) r_hh <= w_hh_next;
        SET_MM: if (inc) r_mm <= w_mm_next;
        SET_SS: if (inc) r_ss <= w_ss_next;
        default: ;
      endcase
    end
  end

  // Output logic; edit_field doubles as the visible FSM state
  always_comb begin
    edit_field = r_state;
    hh         = r_hh;
    mm         = r_mm;
    ss         = r_ss;
    day_pulse  = r_day;
  end

endmodule

// File: tb/tb_wallclock_hms.sv
// Directed bench for wallclock_hms: a driver pushes hand-computed expectations into
// a queue and a negedge monitor pops and compares them against both instances.
module tb_wallclock_hms;

  localparam int W = 28;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic drv_reset = 1'b0;
  logic drv_c1s   = 1'b1;
  logic drv_set   = 1'b0;
  logic drv_sel   = 1'b0;
  logic drv_inc   = 1'b0;
  logic phase12   = 1'b0;

  logic rst24, c1s24, set24, sel24, inc24;
  logic rst12, c1s12, set12, sel12, inc12;
  logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
  logic [1:0] ef24, ef12;
  logic       dp24, dp12;

  assign rst24 = phase12 ? 1'b1 : drv_reset;
  assign c1s24 = phase12 ? 1'b1 : drv_c1s;
  assign set24 = phase12 ? 1'b0 : drv_set;
  assign sel24 = phase12 ? 1'b0 : drv_sel;
  assign inc24 = phase12 ? 1'b0 : drv_inc;
  assign rst12 = phase12 ? drv_reset : 1'b0;
  assign c1s12 = drv_c1s;
  assign set12 = phase12 ? drv_set : 1'b0;
  assign sel12 = phase12 ? drv_sel : 1'b0;
  assign inc12 = phase12 ? drv_inc : 1'b0;

  wallclock_hms #(.HOURS(24), .RST_HH(8'h00), .RST_MM(8'h00)) u_dut24 (
    .clk(clk), .reset(rst24), .clk_1s(c1s24), .set_mode(set24), .sel(sel24), .inc(inc24),
    .hh(hh24), .mm(mm24), .ss(ss24), .edit_field(ef24), .day_pulse(dp24)
  );

  wallclock_hms #(.HOURS(12), .RST_HH(8'h11), .RST_MM(8'h59)) u_dut12 (
    .clk(clk), .reset(rst12), .clk_1s(c1s12), .set_mode(set12), .sel(sel12), .inc(inc12),
    .hh(hh12), .mm(mm12), .ss(ss12), .edit_field(ef12), .day_pulse(dp12)
  );

  // Scoreboard: entry = {dut12, hh, mm, ss, edit_field, day_pulse}
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  string        mon_nm;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      if (mon_exp[27]) mon_act = {1'b1, hh12, mm12, ss12, ef12, dp12};
      else             mon_act = {1'b0, hh24, mm24, ss24, ef24, dp24};
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got %h:%h:%h ef=%0d dp=%0b, expected %h:%h:%h ef=%0d dp=%0b",
                 mon_nm, mon_act[26:19], mon_act[18:11], mon_act[10:3], mon_act[2:1], mon_act[0],
                 mon_exp[26:19], mon_exp[18:11], mon_exp[10:3], mon_exp[2:1], mon_exp[0]);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic d, input logic [7:0] h, input logic [7:0] m,
                     input logic [7:0] s, input logic [1:0] ef, input logic dp,
                     input string nm);
    exp_q.push_back({d, h, m, s, ef, dp});
    name_q.push_back(nm);
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      drv_inc = 1'b1; step();
      drv_inc = 1'b0; step();
    end
  endtask

  task automatic pulse_sel();
    drv_sel = 1'b1; step();
    drv_sel = 1'b0; step();
  endtask

  task automatic do_tick();
    drv_c1s = 1'b0; step();
    drv_c1s = 1'b1; step();
  endtask

  initial begin
    // Reset held with clk_1s high; no increment on release
    repeat (3) step();
    chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, "reset_state");
    drv_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, "no_tick_after_release");
    end

    // 10-clk clk_1s period, 61 rising edges
    for (int e = 1; e <= 61; e++) begin
      drv_c1s = 1'b0;
      repeat (5) step();
      if (e == 1) chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, "before_first_edge");
      drv_c1s = 1'b1;
      step();
      case (e)
        1:  chk(0, 8'h00, 8'h00, 8'h01, 2'd0, 1'b0, "edge_1");
        59: chk(0, 8'h00, 8'h00, 8'h59, 2'd0, 1'b0, "edge_59");
        60: chk(0, 8'h00, 8'h01, 8'h00, 2'd0, 1'b0, "edge_60_min_carry");
        61: chk(0, 8'h00, 8'h01, 8'h01, 2'd0, 1'b0, "edge_61");
        default: ;
      endcase
      repeat (4) step();
      if (e == 1) chk(0, 8'h00, 8'h00, 8'h01, 2'd0, 1'b0, "one_inc_per_edge");
    end

    // Edit mode basics
    drv_set = 1'b1; step();
    chk(0, 8'h00, 8'h01, 8'h01, 2'd1, 1'b0, "enter_set_hh");
    pulse_inc(5);
    chk(0, 8'h05, 8'h01, 8'h01, 2'd1, 1'b0, "hh_inc_5");
    pulse_sel();
    chk(0, 8'h05, 8'h01, 8'h01, 2'd2, 1'b0, "sel_to_mm");
    pulse_inc(58);
    chk(0, 8'h05, 8'h59, 8'h01, 2'd2, 1'b0, "mm_to_59");
    pulse_inc(1);
    chk(0, 8'h05, 8'h00, 8'h01, 2'd2, 1'b0, "mm_wrap_no_carry");
    do_tick(); do_tick();
    chk(0, 8'h05, 8'h00, 8'h01, 2'd2, 1'b0, "frozen_in_edit");
    drv_c1s = 1'b0; step();
    drv_set = 1'b0; drv_c1s = 1'b1; step();
    chk(0, 8'h05, 8'h00, 8'h01, 2'd0, 1'b0, "tick_dropped_on_return");
    do_tick();
    chk(0, 8'h05, 8'h00, 8'h02, 2'd0, 1'b0, "counting_resumed");

    // Tick on entry edge, then preload 23:59:58
    drv_c1s = 1'b0; step();
    drv_set = 1'b1; drv_c1s = 1'b1; step();
    chk(0, 8'h05, 8'h00, 8'h03, 2'd1, 1'b0, "tick_on_entry");
    pulse_inc(18);
    pulse_sel();
    pulse_inc(59);
    pulse_sel();
    pulse_inc(54);
    chk(0, 8'h23, 8'h59, 8'h57, 2'd3, 1'b0, "preload_ss57");
    drv_inc = 1'b1; drv_set = 1'b0; step();
    drv_inc = 1'b0;
    chk(0, 8'h23, 8'h59, 8'h58, 2'd0, 1'b0, "inc_with_set_fall");
    do_tick();
    chk(0, 8'h23, 8'h59, 8'h59, 2'd0, 1'b0, "pre_wrap");
    do_tick();
    chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, "day_wrap_pulse");
    step();
    chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, "day_pulse_one_cycle");
    drv_inc = 1'b1; drv_sel = 1'b1; step();
    drv_inc = 1'b0; drv_sel = 1'b0;
    chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, "inc_sel_ignored_run");

    // inc+sel together in SET_SS, then reset mid-edit
    drv_set = 1'b1; step();
    pulse_inc(7);
    pulse_sel();
    pulse_inc(33);
    pulse_sel();
    pulse_inc(59);
    chk(0, 8'h07, 8'h33, 8'h59, 2'd3, 1'b0, "ss_at_59");
    drv_inc = 1'b1; drv_sel = 1'b1; step();
    drv_inc = 1'b0; drv_sel = 1'b0;
    chk(0, 8'h07, 8'h33, 8'h00, 2'd1, 1'b0, "inc_sel_same_edge");
    pulse_sel(); pulse_sel();
    pulse_inc(12);
    pulse_sel(); pulse_sel();
    chk(0, 8'h07, 8'h33, 8'h12, 2'd2, 1'b0, "mid_edit_0733_12");
    drv_reset = 1'b0; step();
    chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, "reset_mid_edit");
    drv_reset = 1'b1; drv_set = 1'b0; step();
    chk(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, "after_reset_release");

    // HOURS=12 instance
    phase12 = 1'b1; drv_reset = 1'b0; drv_c1s = 1'b1;
    step(); step();
    chk(1, 8'h11, 8'h59, 8'h00, 2'd0, 1'b0, "h12_reset_preset");
    drv_reset = 1'b1; step();
    drv_set = 1'b1; step();
    pulse_sel(); pulse_sel();
    pulse_inc(59);
    pulse_sel();
    pulse_inc(1);
    chk(1, 8'h00, 8'h59, 8'h59, 2'd1, 1'b0, "h12_edit_hh_wrap");
    pulse_inc(11);
    drv_set = 1'b0; step();
    chk(1, 8'h11, 8'h59, 8'h59, 2'd0, 1'b0, "h12_at_115959");
    do_tick();
    chk(1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, "h12_day_wrap");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
